// File: rtl/channel_fifo_datapath.sv
// rtl/channel_fifo_datapath.sv - two-channel capture FIFO datapath (optional FIFO_ERR_FLAGS_EN sticky flags)
module channel_fifo_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Ch1_Data,
  input  logic [DATA_WIDTH-1:0] Ch2_Data,
  input  logic                  Mux,
  input  logic                  Write,
  input  logic                  Read,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wr_en, rd_en;

  // Status decodes only the registered count so the controller sees clean Moore inputs.
  assign Full  = (cnt_q == CNT_FULL);
  assign Empty = (cnt_q == '0);
  assign wr_en = Write && !Full;
  assign rd_en = Read && !Empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      data_out_d   = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= Mux ? Ch1_Data : Ch2_Data;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (Write && Full);
    underflow_d = underflow_q | (Read && Empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

  assign Count      = cnt_q;
  assign Data_Out   = data_out_q;
  assign Data_Valid = data_valid_q;

endmodule

// File: tb/tb_channel_fifo_datapath.sv
// tb/tb_channel_fifo_datapath.sv - queue-model bench for channel_fifo_datapath
module tb_channel_fifo_datapath;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] Ch1_Data, Ch2_Data;
  logic          Mux, Write, Read;
  logic          Full, Empty, Data_Valid, Overflow, Underflow;
  logic [AW:0]   Count;
  logic [DW-1:0] Data_Out;

  channel_fifo_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .Ch1_Data(Ch1_Data), .Ch2_Data(Ch2_Data),
    .Mux(Mux), .Write(Write), .Read(Read), .Full(Full), .Empty(Empty),
    .Count(Count), .Data_Out(Data_Out), .Data_Valid(Data_Valid),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue holding the FIFO contents.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout  = '0;
  bit            m_valid = 1'b0;
  bit            m_ovf   = 1'b0;
  bit            m_unf   = 1'b0;
  bit            started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      started = 1'b1;
    end else begin
      bit was_full, was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (Write && was_full) m_ovf = 1'b1;
      if (Read && was_empty) m_unf = 1'b1;
      m_valid = 1'b0;
      if (Read && !was_empty) begin
        m_dout  = q.pop_front();
        m_valid = 1'b1;
      end
      if (Write && !was_full) q.push_back(Mux ? Ch1_Data : Ch2_Data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(Count), 32'(q.size()));
      check("full", 32'(Full), 32'(q.size() == DEPTH));
      check("empty", 32'(Empty), 32'(q.size() == 0));
      check("data_valid", 32'(Data_Valid), 32'(m_valid));
      check("data_out", 32'(Data_Out), 32'(m_dout));
      check("overflow", 32'(Overflow), 32'(m_ovf & FLAGS));
      check("underflow", 32'(Underflow), 32'(m_unf & FLAGS));
    end
  end

  task automatic step(input logic w, input logic r, input logic m,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic rst);
    Write = w; Read = r; Mux = m; Ch1_Data = a; Ch2_Data = b; reset = rst;
    @(negedge clk);
  endtask

  initial begin
    Write = 0; Read = 0; Mux = 0; Ch1_Data = 0; Ch2_Data = 0; reset = 1;
    @(negedge clk);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    check("lit_reset_empty", 32'(Empty), 32'd1);
    check("lit_reset_count", 32'(Count), 32'd0);

    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'(8'h11 + i), 8'hEE, 0);
    check("lit_fill_count", 32'(Count), 32'd4);
    check("lit_fill_full", 32'(Full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00, 8'h00, 0);
      check("lit_drain_data", 32'(Data_Out), 32'(8'h11 + i));
      check("lit_drain_valid", 32'(Data_Valid), 32'd1);
    end
    check("lit_drain_empty", 32'(Empty), 32'd1);

    step(1, 0, 0, 8'h5A, 8'hA5, 0);
    step(0, 1, 0, 8'h00, 8'h00, 0);
    check("lit_mux_ch2", 32'(Data_Out), 32'hA5);

    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'(i + 1), 8'h00, 0);
    step(1, 1, 1, 8'h99, 8'h00, 0);
    check("lit_full_rw_count", 32'(Count), 32'd3);
    check("lit_full_rw_data", 32'(Data_Out), 32'd1);
    check("lit_full_rw_ovf", 32'(Overflow), 32'(FLAGS));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 8'h00, 0);
    check("lit_full_rw_last", 32'(Data_Out), 32'd4);

    step(1, 1, 1, 8'h77, 8'h00, 0);
    check("lit_empty_rw_count", 32'(Count), 32'd1);
    check("lit_empty_rw_valid", 32'(Data_Valid), 32'd0);
    check("lit_empty_rw_unf", 32'(Underflow), 32'(FLAGS));
    step(0, 1, 0, 8'h00, 8'h00, 0);
    check("lit_empty_rw_data", 32'(Data_Out), 32'h77);

    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 3; i++) step(1, 0, 1, 8'(8'h30 + rep * 3 + i), 8'h00, 0);
      for (int i = 0; i < 3; i++) begin
        step(0, 1, 0, 8'h00, 8'h00, 0);
        check("lit_wrap_data", 32'(Data_Out), 32'(8'h30 + rep * 3 + i));
      end
    end
    check("lit_wrap_count", 32'(Count), 32'd0);

    step(1, 0, 1, 8'h01, 8'h00, 0);
    step(1, 0, 1, 8'h02, 8'h00, 0);
    step(1, 0, 1, 8'h03, 8'h00, 1);
    check("lit_rst_count", 32'(Count), 32'd0);
    check("lit_rst_empty", 32'(Empty), 32'd1);
    check("lit_rst_valid", 32'(Data_Valid), 32'd0);
    check("lit_rst_flags", 32'({Overflow, Underflow}), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 50),
           logic'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           logic'($urandom_range(0, 199) == 0));
    end

    step(0, 0, 0, 8'h00, 8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
